al_accel_pool_ctrl: RTL and testbench

Sequencer for the al_accel_pool 2x2/stride-2 max-pool datapath and its 13-entry partial-max buffer.
- Accepts a pixel stream over a valid/ready handshake.
- Drives the datapath's enb, cp_enb, mpbuf_ld_wrn, sel_demux and sel_mux for each row pair.
- Drains the pooled row with an output valid/ready handshake.
- Sits between the conv/activation output stream and the accelerator writeback.

---
 rtl/al_accel_pkg.sv | 23 ++
 rtl/al_accel_pool_cnt.sv | 28 ++
 rtl/al_accel_pool_ctrl.sv | 156 +++++++++++++++
 tb/tb_al_accel_pool_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/al_accel_pkg.sv
// Shared types, sizing constants and config check for the al_accel pooling block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package al_accel_pkg;

    localparam int POOL_BUF_DEPTH = 13;
    localparam int POOL_SEL_W     = 4;

    typedef enum logic [2:0] {
        PC_IDLE,
        PC_ROW_A,
        PC_ROW_B,
        PC_DRAIN,
        PC_FIN
    } pool_ctrl_state_t;

    // Row width must be even and fit the partial-max buffer; height must be whole row pairs.
    function automatic logic is_pool_cfg_legal(input logic [4:0] width, input logic [15:0] height);
        return (width != 5'd0) && !width[0] && (width <= 5'(2 * POOL_BUF_DEPTH)) &&
               (height != 16'd0) && !height[0];
    endfunction

endpackage

// File: rtl/al_accel_pool_cnt.sv
// Wrap counter: counts on en, returns to 0 after reaching lim, clr has priority.
// Latency: count visible one cycle after en; wrap is combinational.
// Backpressure: holds its value whenever en is low.
module al_accel_pool_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] lim,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/al_accel_pool_ctrl.sv
// Sequencer for the 2x2/stride-2 max-pool datapath; optional stall counters under AL_POOL_CTRL_PERF_EN.
// Latency: pixel controls combinational with the input transfer; one pooled result per cycle in DRAIN.
// Backpressure: in_valid gaps and out_ready low hold every counter; in_ready only in ROW_A/ROW_B.
module al_accel_pool_ctrl
    import al_accel_pkg::*;
#(
    parameter int BUF_DEPTH = POOL_BUF_DEPTH,
    parameter int SEL_W     = POOL_SEL_W,
    parameter int DIM_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [4:0]       cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pool_enb,
    output logic             pool_cp_enb,
    output logic             pool_ld_wrn,
    output logic [SEL_W-1:0] pool_sel_demux,
    output logic [SEL_W-1:0] pool_sel_mux,
    output logic             busy,
    output logic             done,
`ifdef AL_POOL_CTRL_PERF_EN
    output logic             cfg_err,
    output logic [15:0]      perf_in_stall,
    output logic [15:0]      perf_out_stall
`else
    output logic             cfg_err
`endif
);

    localparam logic [5:0] MAX_W = 6'(2 * BUF_DEPTH);

    pool_ctrl_state_t state_q, state_d;

    logic [4:0]       cfg_w_q;
    logic [DIM_W-1:0] cfg_h_q;
    logic             cfg_ok;
    logic             start_idle;
    logic             xfer;
    logic             acc;
    logic             ctr_clr;
    logic [4:0]       col_cnt;
    logic             col_wrap;
    logic [SEL_W-1:0] idx_cnt;
    logic [SEL_W-1:0] idx_lim;
    logic             idx_wrap;
    logic [DIM_W-1:0] row_cnt;
    logic             row_wrap_unused;
    logic             row_done;

    assign cfg_ok     = is_pool_cfg_legal(cfg_width, 16'(cfg_height)) && ({1'b0, cfg_width} <= MAX_W);
    assign start_idle = (state_q == PC_IDLE) && start && !abort;

    assign in_ready  = (state_q == PC_ROW_A) || (state_q == PC_ROW_B);
    assign out_valid = (state_q == PC_DRAIN);
    assign xfer      = in_valid && in_ready;
    assign acc       = out_valid && out_ready;
    assign busy      = (state_q != PC_IDLE);
    assign done      = (state_q == PC_FIN);

    assign pool_enb       = xfer;
    assign pool_ld_wrn    = (state_q == PC_ROW_A) && !col_cnt[0];
    assign pool_cp_enb    = xfer && ((state_q == PC_ROW_B) || ((state_q == PC_ROW_A) && col_cnt[0]));
    assign pool_sel_demux = SEL_W'(col_cnt[4:1]);
    assign pool_sel_mux   = (state_q == PC_DRAIN) ? idx_cnt : '0;

    // Counters sit at zero while idle so each frame starts clean.
    assign ctr_clr = abort || (state_q == PC_IDLE);
    assign idx_lim = SEL_W'(cfg_w_q[4:1]) - SEL_W'(1);

    al_accel_pool_cnt #(.W(5)) u_col_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .en   (xfer),
        .lim  (cfg_w_q - 5'd1),
        .cnt  (col_cnt),
        .wrap (col_wrap)
    );

    al_accel_pool_cnt #(.W(SEL_W)) u_idx_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .en   (acc),
        .lim  (idx_lim),
        .cnt  (idx_cnt),
        .wrap (idx_wrap)
    );

    // Counts completed row pairs (row/2); never reaches its all-ones limit for a legal height.
    al_accel_pool_cnt #(.W(DIM_W)) u_row_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .en   ((state_q == PC_ROW_B) && col_wrap),
        .lim  ('1),
        .cnt  (row_cnt),
        .wrap (row_wrap_unused)
    );

    assign row_done = (row_cnt == (cfg_h_q >> 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_IDLE:  if (start_idle && cfg_ok) state_d = PC_ROW_A;
            PC_ROW_A: if (col_wrap) state_d = PC_ROW_B;
            PC_ROW_B: if (col_wrap) state_d = PC_DRAIN;
            PC_DRAIN: if (idx_wrap) state_d = row_done ? PC_FIN : PC_ROW_A;
            PC_FIN:   state_d = PC_IDLE;
            default:  state_d = PC_IDLE;
        endcase
        if (abort) state_d = PC_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PC_IDLE;
            cfg_w_q <= '0;
            cfg_h_q <= '0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_err <= start_idle && !cfg_ok;
            if (start_idle && cfg_ok) begin
                cfg_w_q <= cfg_width;
                cfg_h_q <= cfg_height;
            end
        end
    end

`ifdef AL_POOL_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_in_stall  <= '0;
            perf_out_stall <= '0;
        end else if (start && (state_q == PC_IDLE)) begin
            perf_in_stall  <= '0;
            perf_out_stall <= '0;
        end else begin
            if (in_ready && !in_valid && (perf_in_stall != 16'hFFFF))
                perf_in_stall <= perf_in_stall + 16'd1;
            if (out_valid && !out_ready && (perf_out_stall != 16'hFFFF))
                perf_out_stall <= perf_out_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_al_accel_pool_ctrl.sv
// Directed bench for al_accel_pool_ctrl with a behavioural pool buffer and a result scoreboard.
module tb_al_accel_pool_ctrl;

    logic       clk;
    logic       rst, start, abort;
    logic [4:0] cfg_width;
    logic [7:0] cfg_height;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       pool_enb, pool_cp_enb, pool_ld_wrn;
    logic [3:0] pool_sel_demux, pool_sel_mux;
    logic       busy, done, cfg_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    al_accel_pool_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pool_enb       (pool_enb),
        .pool_cp_enb    (pool_cp_enb),
        .pool_ld_wrn    (pool_ld_wrn),
        .pool_sel_demux (pool_sel_demux),
        .pool_sel_mux   (pool_sel_mux),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    // Behavioural datapath: raw load, signed max write, read mux.
    logic [7:0] pool_di;
    logic [7:0] mbuf [0:15];
    logic [7:0] pool_do;
    assign pool_do = mbuf[pool_sel_mux];

    logic [7:0] pix [0:255];

    typedef struct packed {
        logic [7:0] val;
        logic [3:0] idx;
    } exp_t;
    exp_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0, out_cnt = 0;
    int   enb_cnt = 0, ldw_cnt = 0, max_demux = 0;
    logic took_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [7:0] gold(input int w, input int p, input int j);
        int base;
        base = 2 * p * w + 2 * j;
        return smax(smax(pix[base], pix[base+1]), smax(pix[base+w], pix[base+w+1]));
    endfunction

    task automatic push_frame(input int w, input int h);
        exp_t e;
        for (int p = 0; p < h / 2; p++)
            for (int j = 0; j < w / 2; j++) begin
                e.val = gold(w, p, j);
                e.idx = 4'(j);
                exp_q.push_back(e);
            end
    endtask

    // One clock: sample and score at the falling edge, then step to just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=result expected=none_pending");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pool_do", 32'(pool_do), 32'(e.val));
                chk("sel_mux", 32'(pool_sel_mux), 32'(e.idx));
            end
            out_cnt++;
            acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (in_ready && !in_valid) chk("stall_no_enb", 32'(pool_enb), 32'd0);
        if (pool_enb) begin
            enb_cnt++;
            if (int'(pool_sel_demux) > max_demux) max_demux = int'(pool_sel_demux);
            if (pool_ld_wrn) begin
                ldw_cnt++;
                mbuf[pool_sel_demux] = pool_di;
            end else if (pool_cp_enb) begin
                mbuf[pool_sel_demux] = smax(mbuf[pool_sel_demux], pool_di);
            end
        end
        took_in = in_valid && in_ready;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        cfg_width  = 5'(w);
        cfg_height = 8'(h);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int w, input int h,
                             input bit gaps, input bit ostall, input bit poke);
        int   d0, oc0, pi, sl, n;
        logic [3:0] held;
        d0 = done_cnt; oc0 = out_cnt; pi = 0; sl = 3; n = w * h; held = '0;
        push_frame(w, h);
        do_start(w, h);
        for (int c = 0; c < 4000 && done_cnt == d0; c++) begin
            in_valid = (pi < n) && (!gaps || ($urandom_range(0, 2) != 0));
            if (pi < n) pool_di = pix[pi];
            if (ostall && out_valid && sl > 0) begin
                if (sl == 3) held = pool_sel_mux;
                else chk({tag, "_stall_hold_mux"}, 32'(pool_sel_mux), 32'(held));
                out_ready = 1'b0;
                sl--;
            end else begin
                out_ready = 1'b1;
            end
            start = poke && (c == 5);
            if (poke && c == 5) begin
                cfg_width  = 5'd2;
                cfg_height = 8'd2;
            end
            tick();
            if (took_in) pi++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk({tag, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_outputs"}, 32'(out_cnt - oc0), 32'(n / 4));
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic feed(input int n);
        int pi;
        pi = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 10 * n + 10 && pi < n; c++) begin
            pool_di = pix[pi];
            tick();
            if (took_in) pi++;
        end
        in_valid = 1'b0;
        chk("feed_accepted", 32'(pi), 32'(n));
    endtask

    initial begin
        int e0, d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_width = '0; cfg_height = '0;
        in_valid = 1'b0; out_ready = 1'b1; pool_di = '0; took_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({busy, in_ready, out_valid, done, cfg_err, pool_enb, pool_cp_enb,
                                  pool_ld_wrn, pool_sel_demux, pool_sel_mux}), 32'd0);
        rst = 1'b0;
        tick();

        // Frame from the worked example: results 8 then 9.
        pix[0] = 8'd3; pix[1] = 8'hF9; pix[2] = 8'd5; pix[3] = 8'd9;
        pix[4] = 8'd1; pix[5] = 8'd8;  pix[6] = 8'hFE; pix[7] = 8'd4;
        run_frame("w4h2", 4, 2, 1'b0, 1'b0, 1'b0);
        chk("w4h2_done_lat", 32'(done_cyc - acc_cyc), 32'd1);

        // Widest row: every buffer entry used once.
        for (int i = 0; i < 52; i++) pix[i] = 8'($urandom);
        max_demux = 0; e0 = ldw_cnt;
        run_frame("w26h2", 26, 2, 1'b0, 1'b0, 1'b0);
        chk("w26_max_demux", 32'(max_demux), 32'd12);
        chk("w26_ldwrn_cnt", 32'(ldw_cnt - e0), 32'd13);

        // Illegal configurations.
        e0 = enb_cnt;
        do_start(5, 2);
        chk("badw_cfg_err", 32'(cfg_err), 32'd1);
        chk("badw_busy", 32'(busy), 32'd0);
        in_valid = 1'b1;
        repeat (3) tick();
        chk("badw_err_pulse", 32'(cfg_err), 32'd0);
        do_start(4, 0);
        chk("badh_cfg_err", 32'(cfg_err), 32'd1);
        chk("badh_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        in_valid = 1'b0;
        chk("bad_no_enb", 32'(enb_cnt - e0), 32'd0);

        // Input gaps, output stall and a start while busy.
        for (int i = 0; i < 32; i++) pix[i] = 8'($urandom);
        run_frame("w8h4", 8, 4, 1'b1, 1'b1, 1'b1);
        chk("w8h4_no_cfg_err", 32'(cfg_err), 32'd0);

        // Asynchronous reset between edges in ROW_B.
        for (int i = 0; i < 8; i++) pix[i] = 8'($urandom);
        do_start(4, 2);
        feed(6);
        in_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({busy, in_ready, out_valid, done, cfg_err, pool_enb, pool_cp_enb,
                                      pool_ld_wrn, pool_sel_demux, pool_sel_mux}), 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) pix[i] = 8'($urandom);
        run_frame("w2h2", 2, 2, 1'b0, 1'b0, 1'b0);

        // Abort in DRAIN after the first result.
        for (int i = 0; i < 8; i++) pix[i] = 8'($urandom);
        push_frame(2, 2);
        exp_q.delete();
        exp_q.push_back('{val: gold(4, 0, 0), idx: 4'd0});
        out_ready = 1'b0;
        do_start(4, 2);
        feed(8);
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        chk("abort_in_drain", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("abort_idx1", 32'(pool_sel_mux), 32'd1);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
